ntt_seq_ctrl: RTL and testbench
===============================

# ntt_seq_ctrl

Sequential controller for an 8-point, 8-bit modular NTT/INTT. It accepts eight coefficients over a valid/ready stream and sequences a single shared modular multiply-accumulate through all 64 (i, j) terms, computing twiddle powers incrementally instead of by repeated exponentiation. It applies the inverse-N scale in INTT mode and streams eight results out. It sits between a coefficient source and a polynomial-multiply consumer and replaces the fully combinational transform for area-constrained builds.

## Interface
Parameters:
- None. N = 8 and coefficient width = 8 are fixed.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `mode`  in  1  0 = forward NTT, 1 = inverse NTT. Sampled on the first input beat.
- `omega`  in  8  forward root of unity. Sampled on the first input beat.
- `invOmega`  in  8  inverse root. Sampled on the first input beat.
- `invN`  in  8  inverse of 8 mod `mod`. Sampled on the first input beat.
- `mod`  in  8  modulus. Sampled on the first input beat.
- `in_valid`  in  1  input coefficient valid.
- `in_ready`  out  1  block can accept a coefficient.
- `in_data`  in  8  coefficient x[j], sent in j = 0..7 order.
- `out_valid`  out  1  result valid.
- `out_ready`  in  1  consumer accepts the result.
- `out_data`  out  8  result y[i], sent in i = 0..7 order.
- `out_last`  out  1  high with y[7].
- `busy`  out  1  high in every state except IDLE.
- `err`  out  1  sticky parameter error (see Configuration).

## Operation
- States: IDLE, LOAD, MAC, FIN, OUT.
- IDLE: `in_ready` = 1. An accepted beat latches the parameters, stores x[0] and moves to LOAD.
- LOAD: `in_ready` = 1. Stores x[1..7]. Accepting x[7] moves to MAC, with i = 0, j = 0, acc = 0, fac = 1, step = 1.
- Working root w = `mode` ? `invOmega` : `omega`, taken from the latched values.
- MAC, one cycle per j:
  - acc ← (acc + x[j]·fac) mod `mod`.
  - fac ← (fac·step) mod `mod`.
  - j increments. After j = 7, go to FIN.
- FIN, one cycle:
  - y[i] ← `mode` ? (`invN`·acc) mod `mod` : acc.
  - step ← (step·w) mod `mod`.
  - acc ← 0, fac ← 1, j ← 0, i increments.
  - Next state is MAC if i < 7, otherwise OUT.
- Arithmetic:
  - Products are 16 bits.
  - The sum acc + product is 17 bits before reduction.
  - Every stored value is < `mod`.
  - Inputs with x[j] ≥ `mod` are still reduced correctly, because of the full-width sum.
- OUT:
  - `out_valid` = 1 and `out_data` = y[k].
  - k advances on each `out_valid`&&`out_ready` handshake.
  - The handshake on k = 7 (with `out_last` = 1) returns the block to IDLE.
- `in_ready` = 0 in MAC, FIN and OUT. Input is not accepted during compute or drain.
- Parameter port changes after the first beat have no effect on the frame in progress.

## Timing
- Reset values: `in_ready` = 1, `out_valid` = 0, `out_data` = 0, `out_last` = 0, `busy` = 0, `err` = 0, state = IDLE. All counters and accumulators are cleared.
- `rst` mid-frame, in any state, aborts the frame. No partial output is emitted afterwards.
- Compute takes 72 cycles: 8 × (8 MAC + 1 FIN).
- `out_valid` rises 72 cycles after the edge that accepts x[7].
- With `out_ready` held high, the block returns to IDLE 8 cycles after `out_valid` rises.
- Total with no stalls: 8 + 72 + 8 = 88 cycles per frame.
- While `out_valid` = 1 and `out_ready` = 0, `out_data` and `out_last` hold stable.
- IDLE accepts a new frame's first beat in the cycle right after the final output handshake. No back-to-back overlap is allowed.
- Input gaps (`in_valid` = 0) in LOAD stall the block without a timeout.

## Configuration
- Macro: `NTT_SEQ_PARAM_CHECK_EN`.
- Defined:
  - On the first beat, the block checks `mod` < 2 or `invN` ≥ `mod`.
  - If either holds, it sets `err` (sticky until `rst`) and discards the frame.
  - It then stays in LOAD until 8 beats are consumed, and returns to IDLE with no output.
- Undefined:
  - No checks are made and `err` is tied to 0.
  - With `mod` < 2, every output is 0 when `mod` = 1. `mod` = 0 is illegal, and its output is unspecified but the sequencing is unchanged.

## Test plan
- NTT impulse: `mod` = 17, `omega` = 2, x = {1,0,0,0,0,0,0,0} → y = {1,1,1,1,1,1,1,1}, with `out_valid` rising 72 cycles after x[7].
- NTT constant: same parameters, x = all 1 → y = {8,0,0,0,0,0,0,0}.
- INTT: `mode` = 1, `invOmega` = 9, `invN` = 15, `mod` = 17, x = {8,0,…,0} → y = all 1. Also round-trip a random 8-vector through NTT then INTT and require the original vector back.
- Backpressure: `out_ready` toggled 1-0-0-1 at random on the constant vector → `out_data` stays stable during stalls, the 8 values arrive in order, and `out_last` is high only with y[7].
- Reset in MAC at i = 3: `rst` pulse → all outputs take their reset values the next cycle. The next frame produces correct results.
- With `NTT_SEQ_PARAM_CHECK_EN` defined and `mod` = 1: 8 beats are consumed, `err` = 1, no `out_valid`, and the block returns to IDLE.

Source files
------------

// File: rtl/ntt_seq_ctrl.sv
// rtl/ntt_seq_ctrl.sv - sequential 8-point 8-bit modular NTT/INTT controller
// Optional first-beat parameter checking is enabled by `NTT_SEQ_PARAM_CHECK_EN.
module ntt_seq_ctrl (
    input  logic       clk,
    input  logic       rst,
    input  logic       mode,
    input  logic [7:0] omega,
    input  logic [7:0] invOmega,
    input  logic [7:0] invN,
    input  logic [7:0] mod,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [7:0] in_data,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       busy,
    output logic       err
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MAC, S_FIN, S_OUT} state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_mode;
    logic [7:0]  r_omega;
    logic [7:0]  r_inv_omega;
    logic [7:0]  r_inv_n;
    logic [7:0]  r_mod;
    logic [7:0]  r_x [8];
    logic [7:0]  r_y [8];
    logic [2:0]  r_i;
    logic [2:0]  r_j;
    logic [2:0]  r_k;
    logic [7:0]  r_acc;
    logic [7:0]  r_fac;
    logic [7:0]  r_step;
    logic        r_discard;
    logic        w_accept;
    logic        w_out_fire;
    logic        w_bad;
    logic [7:0]  w_root;
    logic [15:0] w_prod;
    logic [16:0] w_sum;

    function automatic logic [7:0] f_mulmod(input logic [7:0] a, input logic [7:0] b,
                                            input logic [7:0] m);
        logic [15:0] p;
        p = {8'd0, a} * {8'd0, b};
        return 8'(p % {8'd0, m});
    endfunction

    assign w_accept   = in_valid && in_ready;
    assign w_out_fire = out_valid && out_ready;
    assign w_root     = r_mode ? r_inv_omega : r_omega;
    assign w_prod     = {8'd0, r_x[r_j]} * {8'd0, r_fac};
    // Full 17-bit sum keeps x[j] >= mod reducing correctly.
    assign w_sum      = {9'd0, r_acc} + {1'b0, w_prod};

`ifdef NTT_SEQ_PARAM_CHECK_EN
    logic r_err;
    assign w_bad = (mod < 8'd2) || (invN >= mod);
    assign err   = r_err;
    always_ff @(posedge clk) begin
        if (rst)
            r_err <= 1'b0;
        else if (r_state == S_IDLE && w_accept && w_bad)
            r_err <= 1'b1;
    end
`else
    assign w_bad = 1'b0;
    assign err   = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_LOAD;
            S_LOAD:  if (w_accept && r_j == 3'd7) w_next = r_discard ? S_IDLE : S_MAC;
            S_MAC:   if (r_j == 3'd7) w_next = S_FIN;
            S_FIN:   w_next = (r_i == 3'd7) ? S_OUT : S_MAC;
            S_OUT:   if (w_out_fire && r_k == 3'd7) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_data  = 8'd0;
        out_last  = 1'b0;
        busy      = 1'b1;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            S_LOAD: in_ready = 1'b1;
            S_OUT: begin
                out_valid = 1'b1;
                out_data  = r_y[r_k];
                out_last  = (r_k == 3'd7);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mode      <= 1'b0;
            r_omega     <= 8'd0;
            r_inv_omega <= 8'd0;
            r_inv_n     <= 8'd0;
            r_mod       <= 8'd0;
            r_i         <= 3'd0;
            r_j         <= 3'd0;
            r_k         <= 3'd0;
            r_acc       <= 8'd0;
            r_fac       <= 8'd0;
            r_step      <= 8'd0;
            r_discard   <= 1'b0;
            for (int n = 0; n < 8; n++) begin
                r_x[n] <= 8'd0;
                r_y[n] <= 8'd0;
            end
        end else begin
            case (r_state)
                S_IDLE: if (w_accept) begin
                    r_mode      <= mode;
                    r_omega     <= omega;
                    r_inv_omega <= invOmega;
                    r_inv_n     <= invN;
                    r_mod       <= mod;
                    r_x[0]      <= in_data;
                    r_j         <= 3'd1;
                    r_discard   <= w_bad;
                end
                S_LOAD: if (w_accept) begin
                    r_x[r_j] <= in_data;
                    r_j      <= r_j + 3'd1;
                    if (r_j == 3'd7) begin
                        r_i    <= 3'd0;
                        r_acc  <= 8'd0;
                        r_fac  <= 8'd1;
                        r_step <= 8'd1;
                    end
                end
                S_MAC: begin
                    r_acc <= 8'(w_sum % {9'd0, r_mod});
                    r_fac <= f_mulmod(r_fac, r_step, r_mod);
                    r_j   <= r_j + 3'd1;
                end
                S_FIN: begin
                    r_y[r_i] <= r_mode ? f_mulmod(r_inv_n, r_acc, r_mod) : r_acc;
                    // step walks w^i so the next row's fac sequence is w^(i*j)
                    r_step   <= f_mulmod(r_step, w_root, r_mod);
                    r_acc    <= 8'd0;
                    r_fac    <= 8'd1;
                    r_j      <= 3'd0;
                    r_i      <= r_i + 3'd1;
                end
                S_OUT: if (w_out_fire) r_k <= r_k + 3'd1;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_ntt_seq_ctrl.sv
// tb/tb_ntt_seq_ctrl.sv - scoreboard bench for ntt_seq_ctrl against a direct-sum NTT model
`timescale 1ns/1ps
module tb_ntt_seq_ctrl;
    typedef logic [7:0] vec_t [8];

    logic       clk = 1'b0;
    logic       rst;
    logic       mode;
    logic [7:0] omega;
    logic [7:0] invOmega;
    logic [7:0] invN;
    logic [7:0] mod;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] in_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;
    logic       busy;
    logic       err;

    int         checks = 0;
    int         errors = 0;
    logic [8:0] exp_q [$];
    bit         bp_en = 1'b0;
    bit         stalled = 1'b0;
    logic [7:0] held_data;
    logic       held_last;

    ntt_seq_ctrl dut (
        .clk(clk), .rst(rst), .mode(mode), .omega(omega), .invOmega(invOmega),
        .invN(invN), .mod(mod), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int powmod(input int b, input int e, input int m);
        int r;
        r = 1 % m;
        for (int n = 0; n < e; n++) r = (r * (b % m)) % m;
        return r;
    endfunction

    // y[i] = sum_j x[j] * w^(i*j) mod m, optionally scaled by invN
    function automatic vec_t ref_transform(input logic md, input int wf, input int wi,
                                           input int ninv, input int m, input vec_t x);
        vec_t y;
        int   s;
        int   w;
        w = md ? wi : wf;
        for (int i = 0; i < 8; i++) begin
            s = 0;
            for (int j = 0; j < 8; j++) s = (s + int'(x[j]) * powmod(w, i * j, m)) % m;
            if (md) s = (ninv * s) % m;
            y[i] = 8'(s);
        end
        return y;
    endfunction

    task automatic push_vec(input vec_t y);
        for (int k = 0; k < 8; k++) exp_q.push_back({1'(k == 7), y[k]});
    endtask

    always @(negedge clk) begin
        logic [8:0] e;
        if (rst) begin
            stalled = 1'b0;
        end else if (out_valid) begin
            if (stalled) begin
                check("hold_data", 32'(out_data), 32'(held_data));
                check("hold_last", 32'(out_last), 32'(held_last));
            end
            if (out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(e[7:0]));
                    check("out_last", 32'(out_last), 32'(e[8]));
                end
                stalled = 1'b0;
            end else begin
                stalled   = 1'b1;
                held_data = out_data;
                held_last = out_last;
            end
        end else begin
            stalled = 1'b0;
        end
    end

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // post: 0 = full frame, >0 = reset that many cycles after x[7], -1 = discarded frame
    task automatic send_frame(input logic md, input logic [7:0] wf, input logic [7:0] wi,
                              input logic [7:0] ninv, input logic [7:0] m, input vec_t x,
                              input int post);
        int cnt;
        for (int b = 0; b < 8; b++) begin
            if (b > 0 && $urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
            in_valid = 1'b1;
            in_data  = x[b];
            if (b == 0) begin
                mode = md; omega = wf; invOmega = wi; invN = ninv; mod = m;
            end
            @(negedge clk);
            check("in_ready", 32'(in_ready), 32'd1);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            if (b == 0) begin
                mode = 1'($urandom); omega = 8'($urandom); invOmega = 8'($urandom);
                invN = 8'($urandom); mod = 8'($urandom);
            end
        end
        if (post < 0) begin
            check("discard_idle", 32'(busy), 32'd0);
            check("discard_err", 32'(err), 32'd1);
            repeat (100) @(posedge clk);
            #1;
            check("discard_busy", 32'(busy), 32'd0);
        end else if (post > 0) begin
            repeat (post) @(posedge clk);
            #1;
            check("abort_busy_before", 32'(busy), 32'd1);
            rst = 1'b1;
            @(posedge clk);
            #1;
            check("abort_in_ready", 32'(in_ready), 32'd1);
            check("abort_out_valid", 32'(out_valid), 32'd0);
            check("abort_out_data", 32'(out_data), 32'd0);
            check("abort_out_last", 32'(out_last), 32'd0);
            check("abort_busy", 32'(busy), 32'd0);
            check("abort_err", 32'(err), 32'd0);
            exp_q.delete();
            rst = 1'b0;
        end else begin
            cnt = 0;
            while (!out_valid && cnt < 200) begin
                @(posedge clk);
                #1;
                check("no_input_while_busy", 32'(in_ready), 32'd0);
                cnt++;
            end
            check("latency", 32'(cnt), 32'd72);
            cnt = 0;
            while (busy && cnt < 500) begin
                @(posedge clk);
                #1;
                cnt++;
            end
            if (!bp_en) check("drain_cycles", 32'(cnt), 32'd8);
            check("idle_after_drain", 32'(busy), 32'd0);
            check("queue_empty", 32'(exp_q.size()), 32'd0);
        end
    endtask

    initial begin
        vec_t x;
        vec_t y;
        vec_t ones;
        logic [7:0] m;
        logic [7:0] ni;
        logic       md;

        rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; mode = 1'b0;
        omega = 8'd0; invOmega = 8'd0; invN = 8'd0; mod = 8'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        for (int k = 0; k < 8; k++) ones[k] = 8'd1;

        x = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_vec(ones);
        send_frame(1'b0, 8'd2, 8'd9, 8'd15, 8'd17, x, 0);

        y = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_vec(y);
        send_frame(1'b0, 8'd2, 8'd9, 8'd15, 8'd17, ones, 0);

        push_vec(ones);
        send_frame(1'b1, 8'd2, 8'd9, 8'd15, 8'd17, y, 0);

        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < 8; k++) x[k] = 8'($urandom_range(0, 16));
            y = ref_transform(1'b0, 2, 9, 15, 17, x);
            push_vec(y);
            send_frame(1'b0, 8'd2, 8'd9, 8'd15, 8'd17, x, 0);
            push_vec(x);
            send_frame(1'b1, 8'd2, 8'd9, 8'd15, 8'd17, y, 0);
        end

        bp_en = 1'b1;
        y = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_vec(y);
        send_frame(1'b0, 8'd2, 8'd9, 8'd15, 8'd17, ones, 0);

        for (int r = 0; r < 6; r++) begin
            bp_en = 1'(r % 2);
            m  = 8'($urandom_range(2, 255));
            ni = 8'($urandom_range(0, int'(m) - 1));
            md = 1'($urandom);
            for (int k = 0; k < 8; k++) x[k] = 8'($urandom);
            omega = 8'($urandom);
            invOmega = 8'($urandom);
            y = ref_transform(md, int'(omega), int'(invOmega), int'(ni), int'(m), x);
            push_vec(y);
            send_frame(md, omega, invOmega, ni, m, x, 0);
        end
        bp_en = 1'b0;

        push_vec(ones);
        x = '{8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        send_frame(1'b0, 8'd2, 8'd9, 8'd15, 8'd17, x, 30);
        y = '{8'd8, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
        push_vec(y);
        send_frame(1'b0, 8'd2, 8'd9, 8'd15, 8'd17, ones, 0);

`ifdef NTT_SEQ_PARAM_CHECK_EN
        send_frame(1'b0, 8'd2, 8'd9, 8'd15, 8'd1, ones, -1);
        check("err_queue_empty", 32'(exp_q.size()), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("err_cleared", 32'(err), 32'd0);
        rst = 1'b0;
`endif

        repeat (5) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
